// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size encodings and byte-lane enable constants for the data memory.
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed little-endian lane(s) of a word and sign/zero extends.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word_i[{lane_i, 3'b000} +: 8];
    h = lane_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = size_i == SZ_BYTE ? {{24{~unsigned_i & b[7]}}, b} :
             size_i == SZ_HALF ? {{16{~unsigned_i & h[15]}}, h} : word_i;
  end
endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressed data memory with sub-word access, fault checks and a store counter.
module data_memory
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addr,
  input  logic [31:0]        wr_data,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [1:0]         size,
  input  logic               load_unsigned,
  output logic [31:0]        rd_data,
  output logic               misaligned,
  output logic               out_of_range,
  output logic               err_sticky,
  output logic [COUNT_W-1:0] store_count
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [31:0]        offset, wmask, wdata, rd_word, ld_data;
  logic [3:0]         be;
  logic [IDX_W-1:0]   idx;
  logic               access, fault, commit, err_q;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  // BASE_ADDR is word aligned, so offset[1:0] equals addr[1:0] for lane and alignment decode
  always_comb begin
    offset = addr - BASE_ADDR;
    idx = offset[IDX_W+1:2];
    access = mem_read | mem_write;
    out_of_range = access && (offset[31:2] >= 30'(DEPTH_WORDS));
    misaligned = access && ((size == SZ_HALF && offset[0]) ||
                            (size == SZ_WORD && offset[1:0] != 2'b00) || size == 2'b11);
    fault = misaligned | out_of_range;
    commit = mem_write & ~fault;
    be = size == SZ_BYTE ? BE_BYTE << offset[1:0] :
         size == SZ_HALF ? (offset[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wdata = size == SZ_BYTE ? {4{wr_data[7:0]}} :
            size == SZ_HALF ? {2{wr_data[15:0]}} : wr_data;
    rd_word = mem_q[idx];
    rd_data = (mem_read && !fault) ? ld_data : '0;
    cnt_d = (commit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  dmem_load_align u_align (
    .word_i    (rd_word),
    .lane_i    (offset[1:0]),
    .size_i    (size),
    .unsigned_i(load_unsigned),
    .data_o    (ld_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (commit) mem_q[idx] <= (mem_q[idx] & ~wmask) | (wdata & wmask);
      if (fault) err_q <= 1'b1;
      cnt_q <= cnt_d;
    end
  end
  assign err_sticky = err_q;
  assign store_count = cnt_q;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed vector table, async-reset sequences and randomized model comparison.
module tb_data_memory;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          CW    = 4;
  logic          clk = 1'b0;
  logic          rst_n, mem_read, mem_write, load_unsigned;
  logic [31:0]   addr, wr_data, rd_data;
  logic [1:0]    size;
  logic          misaligned, out_of_range, err_sticky;
  logic [CW-1:0] store_count;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        r, w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a, d, erd;
    logic        emis, eoor, eerr;
    logic [3:0]  ecnt;
  } vec_t;
  vec_t tv [18];
  logic [7:0] mb [DEPTH*4];
  logic       m_err;
  int         m_cnt;
  data_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_data(wr_data), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned), .rd_data(rd_data),
    .misaligned(misaligned), .out_of_range(out_of_range), .err_sticky(err_sticky),
    .store_count(store_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read = r; mem_write = w; size = sz; load_unsigned = u; addr = a; wr_data = d;
  endtask
  function automatic logic m_mis(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a);
    int n = 1 << sz;
    return (r | w) && (sz == 2'd3 || (a % n) != 0);
  endfunction
  function automatic logic m_oor(input logic r, input logic w, input logic [31:0] a);
    return (r | w) && ((a - BASE) / 4 >= DEPTH);
  endfunction
  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    int n = 1 << sz;
    logic [31:0] v = '0;
    logic [31:0] o = a - BASE;
    for (int i = 0; i < n; i++) v |= 32'(mb[o + i]) << (8 * i);
    if (!u && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction
  initial begin
    tv[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'd0};
    tv[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h20,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 4'd1};
    tv[2]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'd1};
    tv[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h22,  32'h0000007F, 32'h0,        1'b0, 1'b0, 1'b0, 4'd2};
    tv[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hDE7FBEEF, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'hFFFFDE7F, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h23,  32'h0,        32'hFFFFFFDE, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        32'h000000DE, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[8]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'h0000DE7F, 1'b0, 1'b0, 1'b0, 4'd2};
    tv[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h21,  32'h12345678, 32'h0,        1'b1, 1'b0, 1'b1, 4'd2};
    tv[10] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hDE7FBEEF, 1'b0, 1'b0, 1'b1, 4'd2};
    tv[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 4'd2};
    tv[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 4'd2};
    tv[13] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 4'd2};
    tv[14] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 4'd2};
    tv[15] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h40,  32'h11111111, 32'h0,        1'b0, 1'b0, 1'b1, 4'd3};
    tv[16] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h40,  32'h22222222, 32'h11111111, 1'b0, 1'b0, 1'b1, 4'd4};
    tv[17] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        32'h22222222, 1'b0, 1'b0, 1'b1, 4'd4};
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].r, tv[i].w, tv[i].sz, tv[i].u, tv[i].a, tv[i].d);
      #1;
      chk($sformatf("row%0d rd_data", i), rd_data, tv[i].erd);
      chk($sformatf("row%0d misaligned", i), 32'(misaligned), 32'(tv[i].emis));
      chk($sformatf("row%0d out_of_range", i), 32'(out_of_range), 32'(tv[i].eoor));
      @(posedge clk); #1;
      chk($sformatf("row%0d err_sticky", i), 32'(err_sticky), 32'(tv[i].eerr));
      chk($sformatf("row%0d store_count", i), 32'(store_count), 32'(tv[i].ecnt));
      @(negedge clk);
    end
    // mid-cycle async reset: state clears with no clock edge in between
    #2 rst_n = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    #1;
    chk("async store_count", 32'(store_count), 32'd0);
    chk("async err_sticky", 32'(err_sticky), 32'd0);
    chk("async rd_data", rd_data, 32'h0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h44, 32'hAABBCCDD);
    @(posedge clk); #1;
    chk("reset-edge store_count", 32'(store_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    #1 chk("reset-edge dropped store", rd_data, 32'h0);
    for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h0;
    m_err = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      logic r, w, u, mis, oor;
      logic [1:0] sz;
      logic [31:0] a, d, erd;
      int sel;
      @(negedge clk);
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sel = $urandom_range(0, 15);
      a = sel == 0 ? $urandom : sel == 1 ? 32'h3F8 + $urandom_range(0, 15) : $urandom_range(0, 127);
      d = $urandom;
      drive(r, w, sz, u, a, d);
      mis = m_mis(r, w, sz, a);
      oor = m_oor(r, w, a);
      erd = (r && !mis && !oor) ? m_load(sz, u, a) : 32'h0;
      #1;
      chk("rand rd_data", rd_data, erd);
      chk("rand misaligned", 32'(misaligned), 32'(mis));
      chk("rand out_of_range", 32'(out_of_range), 32'(oor));
      @(posedge clk); #1;
      if (mis || oor) m_err = 1'b1;
      else if (w) begin
        for (int i = 0; i < (1 << sz); i++) mb[a - BASE + i] = d[8*i +: 8];
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      chk("rand err_sticky", 32'(err_sticky), 32'(m_err));
      chk("rand store_count", 32'(store_count), 32'(m_cnt));
    end
    chk("store_count saturated", 32'(store_count), 32'((1 << CW) - 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
